// File: rtl/fft_sample_buffer_pkg.sv
// fft_buf_pkg: buffer phase encoding and {imag, real} word-packing constants
package fft_buf_pkg;
  typedef enum logic [1:0] {BUF_FILL, BUF_START, BUF_CALC, BUF_DRAIN} buf_fsm;
  localparam logic [15:0] IMAG_ZERO = 16'h0;
  localparam int REAL_LSB = 0;
  localparam int IMAG_LSB = 16;
endpackage

// File: rtl/fft_sample_buffer_if.sv
// fft_sample_buffer_if: bridge RAM port (write/read/index/sample/loaded/data/calc_end/count), core start/done and core read/write port, error flag
interface fft_sample_buffer_if #(
  parameter int ADDR_WIDTH   = 12,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 32
);
  logic                    i_WRITE_ram;
  logic                    i_READ_ram;
  logic [ADDR_WIDTH-1:0]   i_SAMPLE_INDEX_ram;
  logic [SAMPLE_WIDTH-1:0] i_SAMPLE_ram;
  logic                    i_DATA_LOADED;
  logic [DATA_WIDTH-1:0]   o_DATA_FROM_RAM;
  logic                    o_CALC_END;
  logic [ADDR_WIDTH:0]     o_SAMPLES_NUMBER;
  logic                    o_FFT_START;
  logic                    i_FFT_DONE;
  logic                    i_CORE_RD_EN;
  logic [ADDR_WIDTH-1:0]   i_CORE_RD_ADDR;
  logic [DATA_WIDTH-1:0]   o_CORE_RD_DATA;
  logic                    i_CORE_WR_EN;
  logic [ADDR_WIDTH-1:0]   i_CORE_WR_ADDR;
  logic [DATA_WIDTH-1:0]   i_CORE_WR_DATA;
  logic                    o_ERR_WR;
  modport master (
    output i_WRITE_ram, i_READ_ram, i_SAMPLE_INDEX_ram, i_SAMPLE_ram, i_DATA_LOADED,
           i_FFT_DONE, i_CORE_RD_EN, i_CORE_RD_ADDR, i_CORE_WR_EN, i_CORE_WR_ADDR, i_CORE_WR_DATA,
    input  o_DATA_FROM_RAM, o_CALC_END, o_SAMPLES_NUMBER, o_FFT_START, o_CORE_RD_DATA, o_ERR_WR
  );
  modport slave (
    input  i_WRITE_ram, i_READ_ram, i_SAMPLE_INDEX_ram, i_SAMPLE_ram, i_DATA_LOADED,
           i_FFT_DONE, i_CORE_RD_EN, i_CORE_RD_ADDR, i_CORE_WR_EN, i_CORE_WR_ADDR, i_CORE_WR_DATA,
    output o_DATA_FROM_RAM, o_CALC_END, o_SAMPLES_NUMBER, o_FFT_START, o_CORE_RD_DATA, o_ERR_WR
  );
endinterface

// File: rtl/fft_sample_buffer_mem.sv
// fft_buf_mem: word store with one sync write port (we/wa/wd), comb bridge read (ba->bq) and registered read-before-write core read (re/ra->cq)
module fft_buf_mem #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ba,
  output logic [DATA_WIDTH-1:0] bq,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] cq
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cq <= '0;
    else if (re) cq <= mem[ra];
  end
  assign bq = mem[ba];
endmodule

// File: rtl/fft_sample_buffer.sv
// fft_sample_buffer: fill/start/calc/drain sequencer between AXI bridge and FFT core; ports i_clk, i_rst plus fft_sample_buffer_if.slave bus
module fft_sample_buffer
  import fft_buf_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  fft_sample_buffer_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  buf_fsm state;
  logic [ADDR_WIDTH:0] count, idx_next, wr_cnt;
  logic fill, calc, drain, last_rd, bad, err, we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd, bq, fill_word;
  always_comb begin
    fill = state == BUF_FILL;
    calc = state == BUF_CALC;
    drain = state == BUF_DRAIN;
    idx_next = {1'b0, bus.i_SAMPLE_INDEX_ram} + ONE;
    // count grows to the highest written index + 1, including a write in the loading cycle
    wr_cnt = (fill && bus.i_WRITE_ram && idx_next > count) ? idx_next : count;
    last_rd = drain && bus.i_READ_ram && {1'b0, bus.i_SAMPLE_INDEX_ram} == count - ONE;
    bad = (bus.i_WRITE_ram && !fill) || ((bus.i_CORE_RD_EN || bus.i_CORE_WR_EN) && !calc) || (bus.i_READ_ram && !drain);
    fill_word = (DATA_WIDTH'(IMAG_ZERO) << IMAG_LSB) | (DATA_WIDTH'(SAMPLE_WIDTH'(bus.i_SAMPLE_ram)) << REAL_LSB);
    we = (fill && bus.i_WRITE_ram) || (calc && bus.i_CORE_WR_EN);
    wa = fill ? bus.i_SAMPLE_INDEX_ram : bus.i_CORE_WR_ADDR;
    wd = fill ? fill_word : bus.i_CORE_WR_DATA;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= BUF_FILL;
      count <= '0;
      err <= 1'b0;
    end else begin
      err <= err | bad;
      count <= last_rd ? '0 : wr_cnt;
      state <= (fill && bus.i_DATA_LOADED && wr_cnt != '0) ? BUF_START :
               (state == BUF_START) ? BUF_CALC :
               (calc && bus.i_FFT_DONE) ? BUF_DRAIN :
               last_rd ? BUF_FILL : state;
    end
  end
  fft_buf_mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk(i_clk), .rst(i_rst), .we(we), .wa(wa), .wd(wd),
    .ba(bus.i_SAMPLE_INDEX_ram), .bq(bq),
    .re(calc && bus.i_CORE_RD_EN), .ra(bus.i_CORE_RD_ADDR), .cq(bus.o_CORE_RD_DATA)
  );
  assign bus.o_DATA_FROM_RAM = (drain && bus.i_READ_ram) ? bq : '0;
  assign bus.o_CALC_END = drain;
  assign bus.o_FFT_START = state == BUF_START;
  assign bus.o_SAMPLES_NUMBER = count;
  assign bus.o_ERR_WR = err;
endmodule

// File: doc/fft_sample_buffer.md
Name: fft_sample_buffer

Overview:
- Sample and result store between the AXI bridge and the FFT core.
- The bridge loads real 16-bit samples through its RAM-side port. The buffer then starts the FFT core and gives the core an in-place read/write port.
- When the core reports done, the buffer raises calc-end and serves result words back to the bridge for AXI read-out.
- Closes the bridge's i_DATA_FROM_RAM / i_CALC_END / i_SAMPLES_NUMBER loop.

Parameters:
- ADDR_WIDTH, 12, sample index width; depth = 2**ADDR_WIDTH words.
- SAMPLE_WIDTH, 16, width of a real input sample.
- DATA_WIDTH, 32, stored word width: {imag[31:16], real[15:0]}.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_WRITE_ram  in  1  bridge write strobe.
- i_READ_ram  in  1  bridge read strobe.
- i_SAMPLE_INDEX_ram  in  ADDR_WIDTH  bridge word index.
- i_SAMPLE_ram  in  SAMPLE_WIDTH  bridge sample.
- i_DATA_LOADED  in  1  bridge: last sample present this cycle.
- o_DATA_FROM_RAM  out  DATA_WIDTH  bridge read data, combinational.
- o_CALC_END  out  1  results ready, level.
- o_SAMPLES_NUMBER  out  ADDR_WIDTH+1  number of samples loaded.
- o_FFT_START  out  1  one-cycle start pulse to the core.
- i_FFT_DONE  in  1  core finished, pulse.
- i_CORE_RD_EN  in  1  core read request.
- i_CORE_RD_ADDR  in  ADDR_WIDTH  core read index.
- o_CORE_RD_DATA  out  DATA_WIDTH  core read data, registered.
- i_CORE_WR_EN  in  1  core write strobe.
- i_CORE_WR_ADDR  in  ADDR_WIDTH  core write index.
- i_CORE_WR_DATA  in  DATA_WIDTH  core write data.
- o_ERR_WR  out  1  sticky flag: access made in the wrong phase.

Behaviour:
- Reset values: state BUF_FILL; count=0; o_SAMPLES_NUMBER=0; o_CORE_RD_DATA=0; o_FFT_START=0; o_CALC_END=0; o_ERR_WR=0. Memory contents are not reset.
- Asynchronous i_rst mid-operation aborts any phase: return to BUF_FILL and clear all outputs. A done pulse arriving after reset is ignored.
- States:
  - BUF_FILL: bridge write stores {16'h0, i_SAMPLE_ram} at i_SAMPLE_INDEX_ram. count <= max(count, index+1).
  - Leave BUF_FILL when i_DATA_LOADED=1 and the updated count (including a same-cycle write) is nonzero. Go to BUF_START.
  - i_DATA_LOADED with count still 0 is ignored; stay in BUF_FILL.
  - BUF_START: o_FFT_START=1 for exactly one cycle, then go to BUF_CALC.
  - BUF_CALC: core ports active.
    - Read: o_CORE_RD_DATA <= mem[i_CORE_RD_ADDR] one cycle after i_CORE_RD_EN. The output holds its value when RD_EN=0.
    - Write: mem[i_CORE_WR_ADDR] <= i_CORE_WR_DATA.
    - Same-address read and write in one cycle: the read returns the old data (read-before-write).
    - i_FFT_DONE: go to BUF_DRAIN next cycle.
  - BUF_DRAIN: o_CALC_END=1.
    - o_DATA_FROM_RAM = mem[i_SAMPLE_INDEX_ram] combinationally whenever i_READ_ram=1, because the bridge samples it in the same cycle. Otherwise it drives 0.
    - A read with index == count-1: go to BUF_FILL next cycle; count <= 0; o_CALC_END drops.
- o_SAMPLES_NUMBER = count, held from load through the end of drain.
- Phase violations set o_ERR_WR, which stays set until reset. The access itself is dropped (no memory change, no state change). Violations are:
  - a bridge write outside BUF_FILL;
  - a core read or write outside BUF_CALC;
  - a bridge read outside BUF_DRAIN.
- i_FFT_DONE outside BUF_CALC is ignored and does not set the error flag.
- Index arithmetic is unsigned. count is ADDR_WIDTH+1 bits, so a full buffer reports 2**ADDR_WIDTH without wrap.

Decomposition:
- Package fft_buf_pkg holds:
  - typedef enum buf_fsm {BUF_FILL, BUF_START, BUF_CALC, BUF_DRAIN};
  - localparam IMAG_ZERO (16'h0);
  - word-packing helper constants (REAL_LSB=0, IMAG_LSB=16).
- Sub-module fft_buf_mem holds the storage array:
  - one synchronous write port, muxed between bridge and core by state;
  - one combinational read port for the bridge;
  - one registered read port for the core.
- The FSM, count and error logic stay in the top module.

Test Plan:
- Fill: writes at indices 0..7 with samples 0x0001..0x0008; i_DATA_LOADED together with the index-7 write. Expect o_SAMPLES_NUMBER=8, o_FFT_START high exactly one cycle later, then BUF_CALC.
- Core path: in BUF_CALC, read index 3 → o_CORE_RD_DATA=0x00000004 on the next cycle. Write 0xABCD1234 to index 3 while reading index 3 in the same cycle → the read returns 0x00000004 and a following read returns 0xABCD1234.
- Drain: i_FFT_DONE, then o_CALC_END=1. Bridge reads indices 0..7 and sees o_DATA_FROM_RAM equal to the stored words in the same cycle. After the index-7 read, o_CALC_END=0, state is BUF_FILL and o_SAMPLES_NUMBER=0.
- Phase errors:
  - a bridge write during BUF_CALC → o_ERR_WR=1 and memory unchanged;
  - a core write during BUF_FILL → also dropped;
  - i_DATA_LOADED with no prior writes → remain in BUF_FILL with no start pulse.
- Reset: assert i_rst in mid-BUF_CALC, asynchronously and between clock edges. Expect all outputs to clear immediately and the state to be BUF_FILL. A later i_FFT_DONE has no effect.
- Full depth: write index 4095 only, with i_DATA_LOADED → o_SAMPLES_NUMBER=4096 (13 bits, no wrap). The drain completes on the index-4095 read.
